// File: rtl/mem_read_arbiter_if.sv
// AR/R read channel bundle. The "master" side issues read requests and
// consumes read data; the "slave" side accepts requests and returns data.
interface mem_read_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;

   modport master (
      output arvalid, araddr, rready,
      input  arready, rvalid, rdata
   );

   modport slave (
      input  arvalid, araddr, rready,
      output arready, rvalid, rdata
   );
endinterface

// File: rtl/mem_read_arbiter.sv
// Two-requester (IFU, LSU) round-robin read arbiter in front of a single
// shared memory read port; one transaction outstanding at a time.
module mem_read_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clock,
   input  logic                reset,
   mem_read_arbiter_if.slave   ifu,
   mem_read_arbiter_if.slave   lsu,
   mem_read_arbiter_if.master  m
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic              owner_lsu;
   logic              last_lsu;
   logic              m_arvalid_q;

   logic              in_idle;
   logic              in_data;
   logic              ifu_win;
   logic              lsu_win;
   logic [DATA_W-1:0] rdata_w;

   assign in_idle = (state == IDLE);
   assign in_data = (state == DATA);

   // On a tie the requester that did not complete the previous transaction wins.
   assign ifu_win = in_idle && ifu.arvalid && (!lsu.arvalid || last_lsu);
   assign lsu_win = in_idle && lsu.arvalid && !ifu_win;

   assign ifu.arready = ifu_win;
   assign lsu.arready = lsu_win;

   assign m.arvalid = m_arvalid_q;
   assign m.araddr  = addr_q;

   assign ifu.rvalid = in_data && !owner_lsu && m.rvalid;
   assign lsu.rvalid = in_data &&  owner_lsu && m.rvalid;
   assign m.rready   = in_data && (owner_lsu ? lsu.rready : ifu.rready);

   assign rdata_w   = m.rdata;
   assign ifu.rdata = rdata_w;
   assign lsu.rdata = rdata_w;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         addr_q      <= '0;
         owner_lsu   <= 1'b0;
         last_lsu    <= 1'b1;
         m_arvalid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ifu_win || lsu_win) begin
                  addr_q      <= lsu_win ? lsu.araddr : ifu.araddr;
                  owner_lsu   <= lsu_win;
                  m_arvalid_q <= 1'b1;
                  state       <= ADDR;
               end
            end
            ADDR: begin
               if (m.arready) begin
                  m_arvalid_q <= 1'b0;
                  state       <= DATA;
               end
            end
            DATA: begin
               // Round-robin history only advances once the data beat is delivered.
               if (m.rvalid && m.rready) begin
                  last_lsu <= owner_lsu;
                  state    <= IDLE;
               end
            end
            default: begin
               m_arvalid_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed self-checking bench for mem_read_arbiter: single requests,
// round-robin ties, address and data stalls, and reset mid-transaction.
module tb_mem_read_arbiter;

   logic clock;
   logic reset;
   int   tests;
   int   fails;

   mem_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifu_bus ();
   mem_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsu_bus ();
   mem_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_bus ();

   mem_read_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clock (clock),
      .reset (reset),
      .ifu   (ifu_bus),
      .lsu   (lsu_bus),
      .m     (m_bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      ifu_bus.arvalid = 1'b0;
      ifu_bus.araddr  = '0;
      ifu_bus.rready  = 1'b0;
      lsu_bus.arvalid = 1'b0;
      lsu_bus.araddr  = '0;
      lsu_bus.rready  = 1'b0;
      m_bus.arready   = 1'b0;
      m_bus.rvalid    = 1'b0;
      m_bus.rdata     = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Entered just after a negedge in IDLE with request inputs already set.
   task automatic txn(input string tag, input bit exp_lsu,
                      input logic [31:0] exp_addr, input logic [31:0] d);
      #1;
      chk({tag, ".ifu_arready"}, ifu_bus.arready, !exp_lsu);
      chk({tag, ".lsu_arready"}, lsu_bus.arready, exp_lsu);
      chk({tag, ".m_arvalid_idle"}, m_bus.arvalid, 0);
      @(negedge clock);
      m_bus.arready = 1'b1;
      #1;
      chk({tag, ".m_arvalid"}, m_bus.arvalid, 1);
      chk({tag, ".m_araddr"}, m_bus.araddr, exp_addr);
      chk({tag, ".no_arready_addr"}, ifu_bus.arready | lsu_bus.arready, 0);
      @(negedge clock);
      m_bus.arready = 1'b0;
      m_bus.rvalid  = 1'b1;
      m_bus.rdata   = d;
      if (exp_lsu) lsu_bus.rready = 1'b1;
      else         ifu_bus.rready = 1'b1;
      #1;
      chk({tag, ".ifu_rvalid"}, ifu_bus.rvalid, !exp_lsu);
      chk({tag, ".lsu_rvalid"}, lsu_bus.rvalid, exp_lsu);
      chk({tag, ".m_rready"}, m_bus.rready, 1);
      chk({tag, ".ifu_rdata"}, ifu_bus.rdata, d);
      chk({tag, ".lsu_rdata"}, lsu_bus.rdata, d);
      chk({tag, ".m_arvalid_data"}, m_bus.arvalid, 0);
      chk({tag, ".no_arready_data"}, ifu_bus.arready | lsu_bus.arready, 0);
      @(negedge clock);
      m_bus.rvalid   = 1'b0;
      ifu_bus.rready = 1'b0;
      lsu_bus.rready = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      clear_inputs();
      @(negedge clock);
      @(negedge clock);
      #1;
      chk("rst.m_arvalid", m_bus.arvalid, 0);
      chk("rst.m_rready", m_bus.rready, 0);
      chk("rst.ifu_rvalid", ifu_bus.rvalid, 0);
      chk("rst.lsu_rvalid", lsu_bus.rvalid, 0);
      chk("rst.m_araddr", m_bus.araddr, 0);
      @(negedge clock);
      reset = 1'b0;

      // single IFU request
      ifu_bus.arvalid = 1'b1;
      ifu_bus.araddr  = 32'h8000_0000;
      txn("t1", 1'b0, 32'h8000_0000, 32'h0000_0413);

      // tie right after reset: IFU first, then pending LSU without re-request
      do_reset();
      ifu_bus.arvalid = 1'b1;
      ifu_bus.araddr  = 32'h8000_0004;
      lsu_bus.arvalid = 1'b1;
      lsu_bus.araddr  = 32'h8000_1000;
      txn("t2a", 1'b0, 32'h8000_0004, 32'h0000_0011);
      txn("t2b", 1'b1, 32'h8000_1000, 32'h0000_0022);

      // continuous contention alternates
      ifu_bus.araddr = 32'h0000_1000;
      lsu_bus.araddr = 32'h0000_2000;
      txn("t3a", 1'b0, 32'h0000_1000, 32'hA0A0_0001);
      txn("t3b", 1'b1, 32'h0000_2000, 32'hB0B0_0002);
      txn("t3c", 1'b0, 32'h0000_1000, 32'hA0A0_0003);
      txn("t3d", 1'b1, 32'h0000_2000, 32'hB0B0_0004);

      // address stall with late LSU request and IFU address changing after acceptance
      lsu_bus.arvalid = 1'b0;
      ifu_bus.araddr  = 32'h0000_0100;
      #1;
      chk("t4.ifu_arready", ifu_bus.arready, 1);
      @(negedge clock);
      ifu_bus.araddr  = 32'hDEAD_BEEF;
      ifu_bus.arvalid = 1'b0;
      lsu_bus.arvalid = 1'b1;
      lsu_bus.araddr  = 32'h0000_0200;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t4.m_arvalid_stall", m_bus.arvalid, 1);
         chk("t4.m_araddr_stall", m_bus.araddr, 32'h0000_0100);
         chk("t4.lsu_arready_stall", lsu_bus.arready, 0);
         @(negedge clock);
      end
      m_bus.arready = 1'b1;
      #1;
      chk("t4.m_arvalid_accept", m_bus.arvalid, 1);
      @(negedge clock);

      // data stall: memory valid but owner not ready
      m_bus.arready = 1'b0;
      m_bus.rvalid  = 1'b1;
      m_bus.rdata   = 32'h0000_0055;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t5.m_rready_stall", m_bus.rready, 0);
         chk("t5.ifu_rvalid_stall", ifu_bus.rvalid, 1);
         @(negedge clock);
      end
      ifu_bus.rready = 1'b1;
      #1;
      chk("t5.m_rready", m_bus.rready, 1);
      chk("t5.ifu_rdata", ifu_bus.rdata, 32'h0000_0055);
      @(negedge clock);
      ifu_bus.rready = 1'b0;
      #1;
      chk("t5.idle_ifu_rvalid", ifu_bus.rvalid, 0);
      chk("t5.idle_m_rready", m_bus.rready, 0);
      chk("t5.lsu_pending_arready", lsu_bus.arready, 1);
      m_bus.rvalid = 1'b0;

      // LSU transaction interrupted by reset in DATA
      @(negedge clock);
      m_bus.arready = 1'b1;
      #1;
      chk("t6.m_araddr", m_bus.araddr, 32'h0000_0200);
      @(negedge clock);
      m_bus.arready   = 1'b0;
      m_bus.rvalid    = 1'b1;
      lsu_bus.arvalid = 1'b0;
      #1;
      chk("t6.lsu_rvalid_data", lsu_bus.rvalid, 1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("t6.lsu_rvalid_rst", lsu_bus.rvalid, 0);
      chk("t6.ifu_rvalid_rst", ifu_bus.rvalid, 0);
      chk("t6.m_arvalid_rst", m_bus.arvalid, 0);
      chk("t6.m_rready_rst", m_bus.rready, 0);
      chk("t6.m_araddr_rst", m_bus.araddr, 0);
      @(negedge clock);
      lsu_bus.rready = 1'b1;
      #1;
      chk("t6.spurious_lsu_rvalid", lsu_bus.rvalid, 0);
      chk("t6.spurious_m_rready", m_bus.rready, 0);
      chk("t6.no_arready", ifu_bus.arready | lsu_bus.arready, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
